// File: rtl/pong_match_sequencer.sv
// rtl/pong_match_sequencer.sv - Pong match flow controller: serve, rally, point, pause, game over
module pong_match_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int WIN_BY       = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic [6:0] score1,
  input  logic [6:0] score2,
  output logic [2:0] state,
  output logic       ball_hold,
  output logic       ball_launch,
  output logic       serve_dir,
  output logic       score_clear,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    RALLY      = 3'd2,
    POINT      = 3'd3,
    PAUSED     = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LOAD = 8'(POINT_FRAMES);
  localparam logic [7:0] WIN_SC8    = 8'(WIN_SCORE);
  localparam logic [7:0] WIN_BY8    = 8'(WIN_BY);

  state_t     cur_q, cur_n;
  state_t     saved_q, saved_n;
  logic [7:0] cnt_q, cnt_n;
  logic       start_q, pause_q;
  logic       start_edge, pause_edge;
  logic       hold_n, launch_n, dir_n, clear_n, go_n;
  logic [1:0] win_n;
  logic [7:0] s1, s2;
  logic       p1_wins, p2_wins;

  assign start_edge = start_btn & ~start_q;
  assign pause_edge = pause_btn & ~pause_q;

  // Zero-extend to 8 bits so score + WIN_BY never wraps
  assign s1      = {1'b0, score1};
  assign s2      = {1'b0, score2};
  assign p1_wins = (s1 >= WIN_SC8) && (s1 >= s2 + WIN_BY8);
  assign p2_wins = (s2 >= WIN_SC8) && (s2 >= s1 + WIN_BY8);

  assign state = cur_q;

  // Next-state, counter and registered-output values
  always_comb begin
    cur_n    = cur_q;
    saved_n  = saved_q;
    cnt_n    = cnt_q;
    dir_n    = serve_dir;
    win_n    = winner;
    launch_n = 1'b0;
    clear_n  = 1'b0;
    case (cur_q)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          cur_n   = SERVE_WAIT;
          clear_n = 1'b1;
          dir_n   = 1'b0;
          win_n   = 2'b00;
          cnt_n   = SERVE_LOAD;
        end
      end
      SERVE_WAIT: begin
        // A tick coincident with the pause edge is dropped, cnt frozen
        if (pause_edge) begin
          cur_n   = PAUSED;
          saved_n = SERVE_WAIT;
        end else if (frame_tick) begin
          if (cnt_q == 8'd0) begin
            cur_n    = RALLY;
            launch_n = 1'b1;
          end else begin
            cnt_n = cnt_q - 8'd1;
          end
        end
      end
      RALLY: begin
        if (pause_edge) begin
          cur_n   = PAUSED;
          saved_n = RALLY;
        end else if (point_p1) begin
          cur_n = POINT;
          dir_n = 1'b0;
          cnt_n = POINT_LOAD;
        end else if (point_p2) begin
          cur_n = POINT;
          dir_n = 1'b1;
          cnt_n = POINT_LOAD;
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == 8'd0) begin
            if (p1_wins) begin
              cur_n = GAME_OVER;
              win_n = 2'b01;
            end else if (p2_wins) begin
              cur_n = GAME_OVER;
              win_n = 2'b10;
            end else begin
              cur_n = SERVE_WAIT;
              cnt_n = SERVE_LOAD;
            end
          end else begin
            cnt_n = cnt_q - 8'd1;
          end
        end
      end
      PAUSED: begin
        if (pause_edge) begin
          cur_n = saved_q;
        end
      end
      default: cur_n = IDLE;
    endcase
    hold_n = (cur_n != RALLY);
    go_n   = (cur_n == GAME_OVER);
  end

  // State, counter, button history and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q       <= IDLE;
      saved_q     <= SERVE_WAIT;
      cnt_q       <= 8'd0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      ball_hold   <= 1'b1;
      ball_launch <= 1'b0;
      serve_dir   <= 1'b0;
      score_clear <= 1'b0;
      winner      <= 2'b00;
      game_over   <= 1'b0;
    end else begin
      cur_q       <= cur_n;
      saved_q     <= saved_n;
      cnt_q       <= cnt_n;
      start_q     <= start_btn;
      pause_q     <= pause_btn;
      ball_hold   <= hold_n;
      ball_launch <= launch_n;
      serve_dir   <= dir_n;
      score_clear <= clear_n;
      winner      <= win_n;
      game_over   <= go_n;
    end
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// tb/tb_pong_match_sequencer.sv - scoreboard bench for pong_match_sequencer
module tb_pong_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic [6:0] score1 = 7'd0;
  logic [6:0] score2 = 7'd0;
  logic [2:0] state;
  logic       ball_hold, ball_launch, serve_dir, score_clear, game_over;
  logic [1:0] winner;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       hold;
    logic       launch;
    logic       dir;
    logic       clear;
    logic [1:0] win;
    logic       go;
  } exp_t;

  exp_t sb_q[$];

  pong_match_sequencer #(
    .WIN_SCORE(11), .WIN_BY(2), .SERVE_FRAMES(2), .POINT_FRAMES(1)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .start_btn(start_btn), .pause_btn(pause_btn),
    .point_p1(point_p1), .point_p2(point_p2),
    .score1(score1), .score2(score2),
    .state(state), .ball_hold(ball_hold), .ball_launch(ball_launch),
    .serve_dir(serve_dir), .score_clear(score_clear),
    .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [2:0] st, input logic launch,
                              input logic dir, input logic clear, input logic [1:0] win);
    exp_t e;
    e.tag    = tag;
    e.st     = st;
    e.hold   = (st != 3'd2);
    e.launch = launch;
    e.dir    = dir;
    e.clear  = clear;
    e.win    = win;
    e.go     = (st == 3'd5);
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then compare after the edge
  task automatic cyc(input logic rst, input logic ft, input logic sb, input logic pb,
                     input logic p1, input logic p2, input exp_t e);
    exp_t x;
    reset      = rst;
    frame_tick = ft;
    start_btn  = sb;
    pause_btn  = pb;
    point_p1   = p1;
    point_p2   = p2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq({x.tag, ".state"},  8'(state),       8'(x.st));
    check_eq({x.tag, ".hold"},   8'(ball_hold),   8'(x.hold));
    check_eq({x.tag, ".launch"}, 8'(ball_launch), 8'(x.launch));
    check_eq({x.tag, ".dir"},    8'(serve_dir),   8'(x.dir));
    check_eq({x.tag, ".clear"},  8'(score_clear), 8'(x.clear));
    check_eq({x.tag, ".winner"}, 8'(winner),      8'(x.win));
    check_eq({x.tag, ".go"},     8'(game_over),   8'(x.go));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and ignored pause in IDLE
    cyc(1, 0, 0, 0, 0, 0, mk("reset0", 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 0, mk("reset1", 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 0, 0, mk("idle_pause", 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, mk("idle_rel", 0, 0, 0, 0, 0));
    // start -> serve with one-cycle clear, launch on 3rd tick
    cyc(0, 0, 1, 0, 0, 0, mk("start", 1, 0, 0, 1, 0));
    cyc(0, 0, 1, 0, 0, 0, mk("start_held", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("sw_t1", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("sw_t2", 1, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, mk("sw_idle", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("launch1", 2, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, mk("rally1", 2, 0, 0, 0, 0));
    // simultaneous points: P1 wins priority, later P2 ignored in POINT
    cyc(0, 0, 0, 0, 1, 1, mk("both_pts", 3, 0, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 1, mk("pt_p2_ign", 3, 0, 0, 0, 0));
    score1 = 7'd11;
    score2 = 7'd10;
    cyc(0, 1, 0, 0, 0, 0, mk("pt_t1", 3, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("no_win_11_10", 1, 0, 0, 0, 0));
    // pause in SERVE_WAIT with cnt=1; coincident tick not counted
    cyc(0, 1, 0, 0, 0, 0, mk("sw2_t1", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 1, 0, 0, mk("pause_in", 4, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, 0, 0, mk("paused_tick", 4, 0, 0, 0, 0));
    end
    cyc(0, 0, 0, 0, 0, 0, mk("paused_rel", 4, 0, 0, 0, 0));
    cyc(0, 0, 0, 1, 0, 0, mk("resume", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("res_t1", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("launch2", 2, 1, 0, 0, 0));
    // P2 scores, P1 ahead 12-10 wins at point expiry
    cyc(0, 0, 0, 0, 0, 1, mk("pt_p2", 3, 0, 1, 0, 0));
    score1 = 7'd12;
    cyc(0, 1, 0, 0, 0, 0, mk("pt2_t1", 3, 0, 1, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("p1_wins", 5, 0, 1, 0, 1));
    cyc(0, 0, 0, 1, 0, 0, mk("go_pause", 5, 0, 1, 0, 1));
    cyc(0, 1, 0, 0, 0, 0, mk("go_hold", 5, 0, 1, 0, 1));
    // restart from GAME_OVER: clear pulse, winner cleared
    cyc(0, 0, 1, 0, 0, 0, mk("restart", 1, 0, 0, 1, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("rs_t1", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, 0, mk("rs_t2_pt", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 1, 0, mk("launch3_pt", 2, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, mk("rally3", 2, 0, 0, 0, 0));
    // reset mid-rally
    cyc(1, 1, 0, 0, 0, 0, mk("mid_reset", 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("post_reset", 0, 0, 0, 0, 0));
    // P2 win path
    score1 = 7'd3;
    score2 = 7'd11;
    cyc(0, 0, 1, 0, 0, 0, mk("start4", 1, 0, 0, 1, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("s4_t1", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("s4_t2", 1, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("launch4", 2, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 1, 0, mk("pt_p1", 3, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("pt4_t1", 3, 0, 0, 0, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("p2_wins", 5, 0, 0, 0, 2));
    check_eq("sb_empty", 8'(sb_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
